// File: rtl/intdiv_seq_cdivb_pkg.sv
// Shared types and helpers for the sequential C/B divider.
// Latency helper mirrors the top-level timing for integrators.
package intdiv_seq_cdivb_pkg;

  typedef struct packed {
    int unsigned loga;
    int unsigned logb;
    int unsigned bits_per_cyc;
    int unsigned ff_in;
  } intdiv_seq_cdivb_params_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DONE
  } intdiv_state_e;

  function automatic int unsigned ceil_div(
    input int unsigned a,
    input int unsigned b
  );
    return (a + b - 1) / b;
  endfunction

  function automatic int unsigned intdiv_seq_cdivb_lat(
    input intdiv_seq_cdivb_params_t p
  );
    return p.ff_in + 1 + ceil_div(p.loga, p.bits_per_cyc);
  endfunction

endpackage

// File: rtl/intdiv_seq_cdivb_step.sv
// One restoring division step: shift in a dividend bit,
// subtract the divisor when it fits.
module intdiv_seq_cdivb_step #(
  parameter int LOGB = 60
) (
  input  logic [LOGB-1:0] rem_i,
  input  logic            bit_i,
  input  logic [LOGB-1:0] b_i,
  output logic [LOGB-1:0] rem_o,
  output logic            q_o
);

  logic [LOGB:0]   sh;
  logic [LOGB-1:0] diff;

  assign sh    = {rem_i, bit_i};
  assign q_o   = (sh >= {1'b0, b_i});
  // True difference is below B, so the low LOGB bits are exact.
  assign diff  = sh[LOGB-1:0] - b_i;
  assign rem_o = q_o ? diff : sh[LOGB-1:0];

endmodule

// File: rtl/intdiv_seq_cdivb.sv
// Iterative C/B divider: Q = C / B, R = C % B,
// with overflow and divide-by-zero flags.
module intdiv_seq_cdivb
  import intdiv_seq_cdivb_pkg::*;
#(
  parameter int LOGA         = 60,
  parameter int LOGB         = 60,
  parameter int BITS_PER_CYC = 1,
  parameter int FF_IN        = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [LOGA+LOGB-1:0] C,
  input  logic [LOGB-1:0]      B,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [LOGA-1:0]      Q,
  output logic [LOGB-1:0]      R,
  output logic                 ovf,
  output logic                 dz
);

  localparam int CW  = LOGA + LOGB;
  localparam int N   = ceil_div(LOGA, BITS_PER_CYC);
  localparam int DW  = N * BITS_PER_CYC;
  localparam int PAD = DW - LOGA;
  localparam int NW  = $clog2(N + 1);
  localparam logic [NW-1:0] ONE = NW'(1);

  intdiv_state_e   state_q, state_d;
  logic [CW-1:0]   c_q, c_d;
  logic [LOGB-1:0] b_q, b_d;
  logic [LOGB-1:0] rem_q, rem_d;
  logic [DW-1:0]   dvd_q, dvd_d;
  logic [LOGA-1:0] qs_q, qs_d;
  logic [NW-1:0]   cnt_q, cnt_d;
  logic [LOGA-1:0] q_q, q_d;
  logic [LOGB-1:0] r_q, r_d;
  logic            ovf_q, ovf_d;
  logic            dz_q, dz_d;

  logic [CW-1:0]   src_c;
  logic [LOGB-1:0] src_b;
  logic [LOGB-1:0] hi;
  logic            init;
  logic            big;

  logic [LOGB-1:0] rc [BITS_PER_CYC+1];
  logic [LOGB-1:0] ro [BITS_PER_CYC];
  logic [BITS_PER_CYC-1:0] qb;
  logic [BITS_PER_CYC-1:0] en;
  logic [LOGA-1:0] qs_n;

  assign src_c = (FF_IN != 0) ? c_q : C;
  assign src_b = (FF_IN != 0) ? b_q : B;
  assign hi    = src_c[CW-1:LOGA];
  assign big   = (hi >= src_b);
  assign init  = (FF_IN != 0) ? (state_q == LOAD)
                              : (state_q == IDLE && in_valid);

  assign rc[0] = rem_q;

  // Padding steps in the final cycle are masked off.
  for (genvar j = 0; j < BITS_PER_CYC; j++) begin : g_step
    intdiv_seq_cdivb_step #(.LOGB(LOGB)) u_step (
      .rem_i (rc[j]),
      .bit_i (dvd_q[DW-1-j]),
      .b_i   (b_q),
      .rem_o (ro[j]),
      .q_o   (qb[j])
    );
    assign en[j]   = !((cnt_q == ONE) && (j >= BITS_PER_CYC - PAD));
    assign rc[j+1] = en[j] ? ro[j] : rc[j];
  end

  always_comb begin
    qs_n = qs_q;
    for (int j = 0; j < BITS_PER_CYC; j++) begin
      if (en[j]) qs_n = {qs_n[LOGA-2:0], qb[j]};
    end
  end

  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    b_d     = b_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    qs_d    = qs_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    r_d     = r_q;
    ovf_d   = ovf_q;
    dz_d    = dz_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          c_d     = C;
          b_d     = B;
          state_d = LOAD;
        end
      end
      LOAD: ;
      RUN: begin
        rem_d = rc[BITS_PER_CYC];
        dvd_d = dvd_q << BITS_PER_CYC;
        qs_d  = qs_n;
        cnt_d = cnt_q - ONE;
        if (cnt_q == ONE) begin
          q_d     = qs_n;
          r_d     = rc[BITS_PER_CYC];
          ovf_d   = 1'b0;
          dz_d    = 1'b0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (init) begin
      if (big) begin
        ovf_d   = 1'b1;
        dz_d    = (src_b == '0);
        q_d     = '1;
        r_d     = '0;
        state_d = DONE;
      end else begin
        rem_d   = hi;
        dvd_d   = DW'(src_c[LOGA-1:0]) << PAD;
        qs_d    = '0;
        cnt_d   = NW'(N);
        state_d = RUN;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      c_q     <= '0;
      b_q     <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      qs_q    <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      ovf_q   <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      b_q     <= b_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      qs_q    <= qs_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      r_q     <= r_d;
      ovf_q   <= ovf_d;
      dz_q    <= dz_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign Q         = q_q;
  assign R         = r_q;
  assign ovf       = ovf_q;
  assign dz        = dz_q;

endmodule

// File: tb/tb_intdiv_seq_cdivb.sv
// Directed bench: an 8/8 divider (1 bit/cycle, input regs) and
// a 7/8 divider (2 bits/cycle, padded, no input regs).
module tb_intdiv_seq_cdivb;

  logic        clk;
  logic        rst_n;
  logic        va, vb, ora, orb;
  logic [15:0] ca;
  logic [14:0] cb;
  logic [7:0]  ba, bb;
  logic        ira, irb, ova, ovb;
  logic [7:0]  qa;
  logic [6:0]  qb;
  logic [7:0]  ra, rb;
  logic        ofa, ofb, dza, dzb;

  int checks;
  int errors;

  intdiv_seq_cdivb #(
    .LOGA(8), .LOGB(8), .BITS_PER_CYC(1), .FF_IN(1)
  ) dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(va), .in_ready(ira), .C(ca), .B(ba),
    .out_valid(ova), .out_ready(ora),
    .Q(qa), .R(ra), .ovf(ofa), .dz(dza)
  );

  intdiv_seq_cdivb #(
    .LOGA(7), .LOGB(8), .BITS_PER_CYC(2), .FF_IN(0)
  ) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(vb), .in_ready(irb), .C(cb), .B(bb),
    .out_valid(ovb), .out_ready(orb),
    .Q(qb), .R(rb), .ovf(ofb), .dz(dzb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic op(
    input bit    sel,
    input int    c,
    input int    b,
    input int    eq,
    input int    er,
    input bit    eovf,
    input bit    edz,
    input int    elat,
    input int    hold,
    input string tag
  );
    int n;
    @(negedge clk);
    if (sel) begin
      cb = 15'(c); bb = 8'(b); vb = 1'b1;
    end else begin
      ca = 16'(c); ba = 8'(b); va = 1'b1;
    end
    @(posedge clk); #1;
    va = 1'b0; vb = 1'b0;
    n = 1;
    while (!(sel ? ovb : ova) && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, ".lat"}, 32'(n), 32'(elat));
    chk({tag, ".q"}, sel ? 32'(qb) : 32'(qa), 32'(eq));
    chk({tag, ".r"}, sel ? 32'(rb) : 32'(ra), 32'(er));
    chk({tag, ".ovf"}, sel ? 32'(ofb) : 32'(ofa), 32'(eovf));
    chk({tag, ".dz"}, sel ? 32'(dzb) : 32'(dza), 32'(edz));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      ca = 16'h9999; ba = 8'd3; va = 1'b1;
      @(posedge clk); #1;
      chk({tag, ".hold_q"}, 32'(qa), 32'(eq));
      chk({tag, ".hold_r"}, 32'(ra), 32'(er));
      chk({tag, ".hold_rdy"}, 32'(ira), 32'd0);
      chk({tag, ".hold_vld"}, 32'(ova), 32'd1);
    end
    @(negedge clk);
    va = 1'b0;
    if (sel) orb = 1'b1; else ora = 1'b1;
    @(posedge clk); #1;
    ora = 1'b0; orb = 1'b0;
    chk({tag, ".idle_vld"}, sel ? 32'(ovb) : 32'(ova), 32'd0);
    chk({tag, ".idle_rdy"}, sel ? 32'(irb) : 32'(ira), 32'd1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    va = 0; vb = 0; ora = 0; orb = 0;
    ca = '0; cb = '0; ba = '0; bb = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("rst.vld", 32'(ova), 32'd0);
    chk("rst.q", 32'(qa), 32'd0);
    chk("rst.r", 32'(ra), 32'd0);
    chk("rst.ovf", 32'(ofa), 32'd0);
    chk("rst.dz", 32'(dza), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst.rdy_a", 32'(ira), 32'd1);
    chk("rst.rdy_b", 32'(irb), 32'd1);

    op(0, 6, 3, 2, 0, 0, 0, 10, 0, "a_6_3");
    op(0, 123, 0, 255, 0, 1, 1, 2, 0, "a_div0");
    op(0, 1280, 5, 255, 0, 1, 0, 2, 0, "a_ovf");
    op(0, 1279, 5, 255, 4, 0, 0, 10, 0, "a_edge");
    op(0, 50000, 200, 250, 0, 0, 0, 10, 5, "a_hold");
    op(0, 65279, 255, 255, 254, 0, 0, 10, 0, "a_max");

    // Abort in the middle of RUN.
    @(negedge clk);
    ca = 16'd40000; ba = 8'd250; va = 1'b1;
    @(posedge clk); #1;
    va = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("abort.vld", 32'(ova), 32'd0);
    chk("abort.q", 32'(qa), 32'd0);
    chk("abort.r", 32'(ra), 32'd0);
    chk("abort.ovf", 32'(ofa), 32'd0);
    chk("abort.dz", 32'(dza), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    op(0, 100, 7, 14, 2, 0, 0, 10, 0, "a_after_rst");

    op(1, 1000, 9, 111, 1, 0, 0, 5, 0, "b_1000_9");
    op(1, 32767, 255, 127, 0, 1, 0, 1, 0, "b_ovf");
    op(1, 32639, 255, 127, 254, 0, 0, 5, 0, "b_edge");
    op(1, 5, 0, 127, 0, 1, 1, 1, 0, "b_div0");
    op(1, 6, 3, 2, 0, 0, 0, 5, 0, "b_6_3");
    op(1, 127, 1, 127, 0, 0, 0, 5, 0, "b_127_1");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
